// File: rtl/seq_divider_if.sv
// Start/result bundle between the ALU controller and the sequential divider.
// The controller drives the request, the divider returns results and status.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Trial subtraction runs on a 4-bit-group carry-lookahead adder with carry-in 1.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave div_if
);
    localparam int CW = $clog2(WIDTH);
    localparam int NG = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] rem_w, rem_w_nx;
    logic [WIDTH-1:0] quo_w, quo_w_nx;
    logic [WIDTH-1:0] den, den_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] quo_r, quo_nx;
    logic [WIDTH-1:0] rem_r, rem_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
    logic             dbz_r, dbz_nx;
    logic             zpend, zpend_nx;

    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] gen, prop, carry, diff;
    logic [NG:0]      gcarry;
    logic             no_borrow;

    assign part = {rem_w, quo_w[WIDTH-1]};

    // Low WIDTH bits of part + ~den + 1; the extra top bit of part
    // folds into the borrow test since ~0 there always propagates.
    always_comb begin
        gen       = part[WIDTH-1:0] & ~den;
        prop      = part[WIDTH-1:0] ^ ~den;
        carry     = '0;
        gcarry    = '0;
        gcarry[0] = 1'b1;
        for (int i = 0; i < NG; i++) begin
            carry[4*i]   = gcarry[i];
            carry[4*i+1] = gen[4*i] | (prop[4*i] & gcarry[i]);
            carry[4*i+2] = gen[4*i+1]
                         | (prop[4*i+1] & gen[4*i])
                         | (prop[4*i+1] & prop[4*i] & gcarry[i]);
            carry[4*i+3] = gen[4*i+2]
                         | (prop[4*i+2] & gen[4*i+1])
                         | (prop[4*i+2] & prop[4*i+1] & gen[4*i])
                         | (&prop[4*i+:3] & gcarry[i]);
            gcarry[i+1]  = gen[4*i+3]
                         | (prop[4*i+3] & gen[4*i+2])
                         | (&prop[4*i+2+:2] & gen[4*i+1])
                         | (&prop[4*i+1+:3] & gen[4*i])
                         | (&prop[4*i+:4] & gcarry[i]);
        end
        diff      = prop ^ carry;
        no_borrow = part[WIDTH] | gcarry[NG];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rem_w_nx = rem_w;
        quo_w_nx = quo_w;
        den_nx   = den;
        cnt_nx   = cnt;
        quo_nx   = quo_r;
        rem_nx   = rem_r;
        dbz_nx   = dbz_r;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        zpend_nx = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (div_if.start) begin
                    if (div_if.divisor != '0) begin
                        rem_w_nx = '0;
                        quo_w_nx = div_if.dividend;
                        den_nx   = div_if.divisor;
                        cnt_nx   = '0;
                        dbz_nx   = 1'b0;
                        busy_nx  = 1'b1;
                        state_nx = RUN;
                    end else begin
                        quo_nx   = '1;
                        rem_nx   = div_if.dividend;
                        dbz_nx   = 1'b1;
                        zpend_nx = 1'b1;
                        state_nx = DONE;
                    end
                end else if (state == DONE && zpend) begin
                    // zero-divisor result was loaded last edge; pulse now
                    done_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                busy_nx  = 1'b1;
                quo_w_nx = {quo_w[WIDTH-2:0], no_borrow};
                rem_w_nx = no_borrow ? diff : part[WIDTH-1:0];
                cnt_nx   = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    quo_nx   = quo_w_nx;
                    rem_nx   = rem_w_nx;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_w  <= '0;
            quo_w  <= '0;
            den    <= '0;
            cnt    <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            zpend  <= 1'b0;
        end else begin
            rem_w  <= rem_w_nx;
            quo_w  <= quo_w_nx;
            den    <= den_nx;
            cnt    <= cnt_nx;
            quo_r  <= quo_nx;
            rem_r  <= rem_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            dbz_r  <= dbz_nx;
            zpend  <= zpend_nx;
        end
    end

    assign div_if.busy        = busy_r;
    assign div_if.done        = done_r;
    assign div_if.quotient    = quo_r;
    assign div_if.remainder   = rem_r;
    assign div_if.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected q/r/dbz queued at issue,
// popped and compared when done pulses.
module tb_seq_divider;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif.slave)
    );

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Presents a request for one edge; returns 1ns after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dif.start = 1'b1;
        dif.dividend = a;
        dif.divisor = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.dividend = $urandom;
        dif.divisor = $urandom;
    endtask

    task automatic wait_done(input int budget, output int cyc,
                             output int busy_cyc, output bit to);
        cyc = 0;
        busy_cyc = 0;
        to = 1'b0;
        while (dif.done !== 1'b1) begin
            if (dif.busy === 1'b1) busy_cyc++;
            if (cyc >= budget) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.start = 1'b1;
        dif.dividend = 32'd50;
        dif.divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.div_by_zero !== 1'b0 ||
            dif.quotient !== '0 || dif.remainder !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b dbz=%b q=%h r=%h exp all 0",
                     dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder);
        end
        @(negedge clk);
        dif.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, bc;
        bit to;
        exp_t e;
        issue(32'd100, 32'd7);
        wait_done(W + 5, cyc, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != W) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d (timeout=%0b)", cyc, W, to);
        end
        checks++;
        if (bc != W) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d exp %0d", bc, W);
        end
        checks++;
        if (dif.quotient !== 32'd14 || dif.remainder !== 32'd2 ||
            dif.div_by_zero !== 1'b0 || dif.quotient !== e.q) begin
            errors++;
            $display("FAIL basic_result q=%0d r=%0d dbz=%b exp q=14 r=2 dbz=0",
                     dif.quotient, dif.remainder, dif.div_by_zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dif.done !== 1'b0 || dif.quotient !== 32'd14 || dif.remainder !== 32'd2) begin
            errors++;
            $display("FAIL done_one_cycle done=%b q=%0d r=%0d exp done=0 q=14 r=2",
                     dif.done, dif.quotient, dif.remainder);
        end
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        bit to;
        exp_t e;
        issue(32'd5, 32'd0);
        wait_done(W + 5, cyc, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != 1 || bc != 0) begin
            errors++;
            $display("FAIL dz_latency got %0d busy=%0d exp 1 busy=0 (timeout=%0b)",
                     cyc, bc, to);
        end
        checks++;
        if (dif.quotient !== e.q || dif.remainder !== e.r || dif.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_result q=%h r=%0d dbz=%b exp q=%h r=%0d dbz=1",
                     dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        bit to;
        exp_t e;
        issue(32'hFFFF_FFFF, 32'd1);
        wait_done(W + 5, cyc, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || dif.quotient !== 32'hFFFF_FFFF || dif.remainder !== '0 ||
            dif.div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL div_one q=%h r=%h dbz=%b exp q=ffffffff r=0 dbz=0",
                     dif.quotient, dif.remainder, dif.div_by_zero);
        end
        dif.start = 1'b1;
        dif.dividend = 32'd3;
        dif.divisor = 32'd10;
        sb.push_back(model(32'd3, 32'd10));
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_done(W + 5, cyc, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != W) begin
            errors++;
            $display("FAIL b2b_latency got %0d exp %0d (timeout=%0b)", cyc, W, to);
        end
        checks++;
        if (dif.quotient !== 32'd0 || dif.remainder !== 32'd3 || dif.remainder !== e.r) begin
            errors++;
            $display("FAIL b2b_result q=%0d r=%0d exp q=0 r=3",
                     dif.quotient, dif.remainder);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, bc;
        bit to;
        exp_t e;
        issue(32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dif.start = 1'b1;
        dif.dividend = 32'd9;
        dif.divisor = 32'd9;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_done(W + 5, cyc, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != W - 5) begin
            errors++;
            $display("FAIL ignore_latency got %0d exp %0d (timeout=%0b)", cyc, W - 5, to);
        end
        checks++;
        if (dif.quotient !== 32'd333 || dif.remainder !== 32'd1 || dif.quotient !== e.q) begin
            errors++;
            $display("FAIL ignore_result q=%0d r=%0d exp q=333 r=1",
                     dif.quotient, dif.remainder);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        void'(sb.pop_back());
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.div_by_zero !== 1'b0 ||
            dif.quotient !== '0 || dif.remainder !== '0) begin
            errors++;
            $display("FAIL midrun_reset busy=%b done=%b dbz=%b q=%h r=%h exp all 0",
                     dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrun_no_done activity=%0d exp 0", seen);
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] ta[6] = '{32'd0, 32'd7, 32'd12345, 32'hFFFF_FFFF,
                                32'hFFFF_FFFE, 32'h8000_0000};
        logic [W-1:0] tb[6] = '{32'd5, 32'd9, 32'd1, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int cyc, bc;
        bit to;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i]);
            wait_done(W + 5, cyc, bc, to);
            e = sb.pop_front();
            checks++;
            if (to || dif.quotient !== e.q || dif.remainder !== e.r ||
                dif.div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL boundary_%0d %h/%h q=%h r=%h exp q=%h r=%h (timeout=%0b)",
                         i, ta[i], tb[i], dif.quotient, dif.remainder, e.q, e.r, to);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int cyc, bc, mode;
        bit to;
        exp_t e;
        for (int n = 0; n < 1000; n++) begin
            mode = $urandom_range(0, 7);
            a = $urandom;
            case (mode)
                0: b = '0;
                1, 2: b = W'($urandom_range(1, 255));
                3: b = a + 1'b1;
                4: a = W'($urandom_range(0, 1000));
                default: b = $urandom;
            endcase
            if (mode == 4) b = $urandom;
            issue(a, b);
            wait_done(W + 5, cyc, bc, to);
            e = sb.pop_front();
            checks++;
            if (to || dif.quotient !== e.q || dif.remainder !== e.r ||
                dif.div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL random %h/%h q=%h r=%h dbz=%b exp q=%h r=%h dbz=%b (timeout=%0b)",
                         a, b, dif.quotient, dif.remainder, dif.div_by_zero,
                         e.q, e.r, e.dbz, to);
            end
        end
    endtask

    initial begin
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_run();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
